ram_cmd_arbiter: RTL and testbench

Shares the single 10-bit command port of the SPI-side RAM between two independent requesters (R0 and R1). Each requester issues a whole read or write transaction as one request. The block arbitrates round-robin and expands the request into the RAM's two-command sequence (address command, then data command). For reads, it waits for the RAM's `tx_valid` and returns the read byte. It sits between the SPI slave / APB bridge front ends and the RAM.

---
 rtl/ram_cmd_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_ram_cmd_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_cmd_arbiter.sv
// Round-robin arbiter that shares the RAM's 10-bit command port between two requesters and
// expands each request into the address/data command pair, waiting for read data when needed.
module ram_cmd_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       r0_req,
  input  logic       r0_we,
  input  logic [7:0] r0_addr,
  input  logic [7:0] r0_wdata,
  output logic       r0_ack,
  output logic       r0_err,
  output logic [7:0] r0_rdata,
  input  logic       r1_req,
  input  logic       r1_we,
  input  logic [7:0] r1_addr,
  input  logic [7:0] r1_wdata,
  output logic       r1_ack,
  output logic       r1_err,
  output logic [7:0] r1_rdata,
  output logic [9:0] ram_din,
  output logic       ram_rx_valid,
  input  logic [7:0] ram_dout,
  input  logic       ram_tx_valid,
  output logic       busy
);

  // Requester handshake: req is a level held until the one-cycle ack; we/addr/wdata are
  // sampled only at grant, and a req still high when IDLE samples it is a new request.

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  state_t     state_q, state_d;
  logic       gid_q, gid_d;
  logic       last_q, last_d;
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] cnt_q, cnt_d;
  logic [9:0] din_q, din_d;
  logic       rxv_q, rxv_d;
  logic       busy_q, busy_d;
  logic       r0_ack_q, r0_ack_d, r1_ack_q, r1_ack_d;
  logic       r0_err_q, r0_err_d, r1_err_q, r1_err_d;
  logic [7:0] r0_rdata_q, r0_rdata_d, r1_rdata_q, r1_rdata_d;

  logic       fin;
  logic       fin_rd;
  logic       fin_err;
  logic [7:0] fin_rdata;

  always_comb begin
    state_d    = state_q;
    gid_d      = gid_q;
    last_d     = last_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    din_d      = din_q;
    rxv_d      = 1'b0;
    r0_ack_d   = 1'b0;
    r1_ack_d   = 1'b0;
    r0_err_d   = r0_err_q;
    r1_err_d   = r1_err_q;
    r0_rdata_d = r0_rdata_q;
    r1_rdata_d = r1_rdata_q;
    fin        = 1'b0;
    fin_rd     = 1'b0;
    fin_err    = 1'b0;
    fin_rdata  = 8'h00;

    unique case (state_q)
      S_IDLE: begin
        if (r0_req || r1_req) begin
          // On contention the requester not served last time wins.
          gid_d   = (r0_req && r1_req) ? ~last_q : r1_req;
          last_d  = gid_d;
          we_d    = gid_d ? r1_we    : r0_we;
          addr_d  = gid_d ? r1_addr  : r0_addr;
          wdata_d = gid_d ? r1_wdata : r0_wdata;
          din_d   = {(we_d ? 2'b00 : 2'b10), addr_d};
          rxv_d   = 1'b1;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        din_d   = we_q ? {2'b01, wdata_q} : {2'b11, 8'h00};
        rxv_d   = 1'b1;
        state_d = S_DATA;
      end
      S_DATA: begin
        if (we_q) begin
          fin = 1'b1;
        end else begin
          cnt_d   = 8'h00;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ram_tx_valid) begin
          fin       = 1'b1;
          fin_rd    = 1'b1;
          fin_rdata = ram_dout;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TIMEOUT_W) begin
            fin     = 1'b1;
            fin_rd  = 1'b1;
            fin_err = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Completion: command port returns to opcode 00, which also clears the RAM's tx_valid.
    if (fin) begin
      state_d = S_DONE;
      din_d   = 10'h000;
      if (gid_q) begin
        r1_ack_d = 1'b1;
        r1_err_d = fin_err;
        if (fin_rd) r1_rdata_d = fin_rdata;
      end else begin
        r0_ack_d = 1'b1;
        r0_err_d = fin_err;
        if (fin_rd) r0_rdata_d = fin_rdata;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gid_q      <= 1'b0;
      last_q     <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      cnt_q      <= 8'h00;
      din_q      <= 10'h000;
      rxv_q      <= 1'b0;
      busy_q     <= 1'b0;
      r0_ack_q   <= 1'b0;
      r1_ack_q   <= 1'b0;
      r0_err_q   <= 1'b0;
      r1_err_q   <= 1'b0;
      r0_rdata_q <= 8'h00;
      r1_rdata_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      gid_q      <= gid_d;
      last_q     <= last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      din_q      <= din_d;
      rxv_q      <= rxv_d;
      busy_q     <= busy_d;
      r0_ack_q   <= r0_ack_d;
      r1_ack_q   <= r1_ack_d;
      r0_err_q   <= r0_err_d;
      r1_err_q   <= r1_err_d;
      r0_rdata_q <= r0_rdata_d;
      r1_rdata_q <= r1_rdata_d;
    end
  end

  assign ram_din      = din_q;
  assign ram_rx_valid = rxv_q;
  assign busy         = busy_q;
  assign r0_ack       = r0_ack_q;
  assign r1_ack       = r1_ack_q;
  assign r0_err       = r0_err_q;
  assign r1_err       = r1_err_q;
  assign r0_rdata     = r0_rdata_q;
  assign r1_rdata     = r1_rdata_q;

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Bench for ram_cmd_arbiter: a registered RAM responder plus a transaction-level reference
// (memory image, last-grantee pointer, per-requester rdata/err) checked every cycle.
module tb_ram_cmd_arbiter;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       r0_req = 1'b0, r0_we = 1'b0;
  logic [7:0] r0_addr = 8'h00, r0_wdata = 8'h00;
  logic       r1_req = 1'b0, r1_we = 1'b0;
  logic [7:0] r1_addr = 8'h00, r1_wdata = 8'h00;
  logic       r0_ack, r0_err, r1_ack, r1_err;
  logic [7:0] r0_rdata, r1_rdata;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout;
  logic       ram_tx_valid;
  logic       busy;

  ram_cmd_arbiter #(.TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- RAM responder ----------------
  logic [7:0] ram_mem [256];
  logic [7:0] ram_wa, ram_ra;
  int         ram_pend;
  int         ram_delay = 0;
  bit         ram_mute = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_tx_valid <= 1'b0;
      ram_dout     <= 8'h00;
      ram_pend     <= 0;
      ram_wa       <= 8'h00;
      ram_ra       <= 8'h00;
      for (int i = 0; i < 256; i++) ram_mem[i] <= 8'h00;
    end else begin
      if (ram_rx_valid) begin
        case (ram_din[9:8])
          2'b00: ram_wa <= ram_din[7:0];
          2'b01: ram_mem[ram_wa] <= ram_din[7:0];
          2'b10: ram_ra <= ram_din[7:0];
          default: begin
            if (!ram_mute) begin
              if (ram_delay == 0) begin
                ram_dout     <= ram_mem[ram_ra];
                ram_tx_valid <= 1'b1;
              end else begin
                ram_pend <= ram_delay;
              end
            end
          end
        endcase
      end else if (ram_pend != 0) begin
        ram_pend <= ram_pend - 1;
        if (ram_pend == 1) begin
          ram_dout     <= ram_mem[ram_ra];
          ram_tx_valid <= 1'b1;
        end
      end
      if (ram_din[9:8] == 2'b00) ram_tx_valid <= 1'b0;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [256];
  logic [7:0] ref_rdata [2];
  logic       ref_err [2];
  bit         ref_last;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    ref_rdata[0] = 8'h00;
    ref_rdata[1] = 8'h00;
    ref_err[0]   = 1'b0;
    ref_err[1]   = 1'b0;
    ref_last     = 1'b1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_din"}, ram_din, 10'h000);
    chk({tag, "_rxv"}, ram_rx_valid, 1'b0);
    chk({tag, "_ack"}, {r1_ack, r0_ack}, 2'b00);
    chk({tag, "_err"}, {r1_err, r0_err}, 2'b00);
    chk({tag, "_r0_rdata"}, r0_rdata, 8'h00);
    chk({tag, "_r1_rdata"}, r1_rdata, 8'h00);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input bit id, input bit we, input logic [7:0] a, input logic [7:0] d);
    if (id) begin
      r1_req = 1'b1; r1_we = we; r1_addr = a; r1_wdata = d;
    end else begin
      r0_req = 1'b1; r0_we = we; r0_addr = a; r0_wdata = d;
    end
  endtask

  // Drop req and scramble the fields right after grant; the latched values must still be used.
  task automatic after_grant(input bit id);
    if (id) begin
      r1_req = 1'b0; r1_we = 1'($urandom); r1_addr = 8'($urandom); r1_wdata = 8'($urandom);
    end else begin
      r0_req = 1'b0; r0_we = 1'($urandom); r0_addr = 8'($urandom); r0_wdata = 8'($urandom);
    end
  endtask

  // Entered at the sample point of the ADDR cycle; leaves at the sample point of the IDLE cycle.
  task automatic check_txn(input bit id, input bit we, input logic [7:0] a, input logic [7:0] d,
                           input int delay, input bit mute);
    int nwait;
    ram_delay = delay;
    ram_mute  = mute;
    ref_last  = id;
    chk("addr_din", ram_din, {(we ? 2'b00 : 2'b10), a});
    chk("addr_rxv", ram_rx_valid, 1'b1);
    chk("addr_busy", busy, 1'b1);
    @(negedge clk);
    chk("data_din", ram_din, we ? {2'b01, d} : 10'h300);
    chk("data_rxv", ram_rx_valid, 1'b1);
    chk("data_ack", {r1_ack, r0_ack}, 2'b00);
    if (!we) begin
      nwait = mute ? T : delay + 1;
      for (int i = 0; i < nwait; i++) begin
        @(negedge clk);
        chk("wait_din", ram_din, 10'h300);
        chk("wait_rxv", ram_rx_valid, 1'b0);
        chk("wait_ack", {r1_ack, r0_ack}, 2'b00);
      end
    end
    @(negedge clk);
    if (we) begin
      ref_mem[a]  = d;
      ref_err[id] = 1'b0;
    end else begin
      ref_rdata[id] = mute ? 8'h00 : ref_mem[a];
      ref_err[id]   = mute;
    end
    chk("done_ack", {r1_ack, r0_ack}, id ? 2'b10 : 2'b01);
    chk("done_din", ram_din, 10'h000);
    chk("done_rxv", ram_rx_valid, 1'b0);
    chk("done_busy", busy, 1'b1);
    chk("done_r0_rdata", r0_rdata, ref_rdata[0]);
    chk("done_r1_rdata", r1_rdata, ref_rdata[1]);
    chk("done_r0_err", r0_err, ref_err[0]);
    chk("done_r1_err", r1_err, ref_err[1]);
    @(negedge clk);
    chk("idle_ack", {r1_ack, r0_ack}, 2'b00);
    chk("idle_busy", busy, 1'b0);
  endtask

  task automatic run_single(input bit id, input bit we, input logic [7:0] a, input logic [7:0] d,
                            input int delay, input bit mute);
    set_req(id, we, a, d);
    @(negedge clk);
    after_grant(id);
    check_txn(id, we, a, d, delay, mute);
  endtask

  // Both request in the same cycle; the winner comes from the reference pointer.
  task automatic run_dual(input bit we0, input logic [7:0] a0, input logic [7:0] d0, input int dl0,
                          input bit we1, input logic [7:0] a1, input logic [7:0] d1, input int dl1);
    bit w;
    set_req(0, we0, a0, d0);
    set_req(1, we1, a1, d1);
    w = !ref_last;
    @(negedge clk);
    after_grant(w);
    if (w) check_txn(1, we1, a1, d1, dl1, 1'b0);
    else   check_txn(0, we0, a0, d0, dl0, 1'b0);
    @(negedge clk);
    after_grant(!w);
    if (w) check_txn(0, we0, a0, d0, dl0, 1'b0);
    else   check_txn(1, we1, a1, d1, dl1, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit         w;
    bit         cw [2];
    logic [7:0] ca [2];
    logic [7:0] cd [2];

    ref_reset();
    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed write then read-back of the same location.
    run_single(0, 1'b1, 8'h3C, 8'hA5, 0, 1'b0);
    run_single(1, 1'b0, 8'h3C, 8'h00, 0, 1'b0);

    // Three consecutive contended grants; each winner re-requests at once.
    for (int i = 0; i < 2; i++) begin
      cw[i] = 1'($urandom); ca[i] = 8'($urandom_range(0, 15)); cd[i] = 8'($urandom);
      set_req(1'(i), cw[i], ca[i], cd[i]);
    end
    for (int k = 0; k < 3; k++) begin
      w = !ref_last;
      @(negedge clk);
      after_grant(w);
      check_txn(w, cw[w], ca[w], cd[w], 0, 1'b0);
      if (k < 2) begin
        cw[w] = 1'($urandom); ca[w] = 8'($urandom_range(0, 15)); cd[w] = 8'($urandom);
        set_req(w, cw[w], ca[w], cd[w]);
      end
    end
    w = !ref_last;
    @(negedge clk);
    after_grant(w);
    check_txn(w, cw[w], ca[w], cd[w], 0, 1'b0);

    // Read timeout, then normal traffic resumes.
    run_single(0, 1'b0, 8'h3C, 8'h00, 0, 1'b1);
    run_single(1, 1'b1, 8'h55, 8'h66, 0, 1'b0);
    run_single(0, 1'b0, 8'h55, 8'h00, T - 1, 1'b0);
    run_single(1, 1'b0, 8'h3C, 8'h00, 2, 1'b0);

    // Randomized mix of single and contended transactions.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 2) begin
        run_dual(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, T - 1),
                 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, T - 1));
      end else begin
        run_single(1'($urandom), 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
                   $urandom_range(0, T - 1), ($urandom_range(0, 7) == 0));
      end
    end

    // Asynchronous reset in the middle of a read wait.
    ram_mute = 1'b1;
    set_req(1, 1'b0, 8'h07, 8'h00);
    @(negedge clk);
    after_grant(1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_values("async_rst");
    ref_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (T + 3) begin
      @(negedge clk);
      chk("post_rst_ack", {r1_ack, r0_ack}, 2'b00);
      chk("post_rst_busy", busy, 1'b0);
    end
    run_dual(1'b1, 8'h11, 8'h22, 0, 1'b0, 8'h11, 8'h00, 1);
    run_dual(1'b0, 8'h11, 8'h00, 0, 1'b1, 8'h12, 8'h34, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed simulation still running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
